// File: rtl/mux2_pkg.sv
// Shared defaults and types for the mux2_unit datapath selector.
package mux2_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 16;

    typedef logic [DEFAULT_CNT_W-1:0] toggle_cnt_t;

endpackage : mux2_pkg

// File: rtl/mux2_unit_if.sv
// Signal bundle between the datapath and mux2_unit; master drives data/select, slave returns results.
interface mux2_unit_if
    import mux2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             s;
    logic             en;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             valid_q;
    logic             sel_q;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output d0, d1, s, en,
        input  y, y_q, valid_q, sel_q, toggle_cnt
    );

    modport slave (
        input  d0, d1, s, en,
        output y, y_q, valid_q, sel_q, toggle_cnt
    );

endinterface : mux2_unit_if

// File: rtl/mux2_sel.sv
// Purely combinational WIDTH-wide 2:1 selector.
module mux2_sel #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] y_o
);

    // The conditional operator merges agreeing bits when s_i is X/Z.
    assign y_o = s_i ? d1_i : d0_i;

endmodule : mux2_sel

// File: rtl/mux2_unit.sv
// 2:1 selector with combinational and registered outputs; toggle counter built only
// when MUX2_TOGGLE_CNT_EN is defined.
module mux2_unit
    import mux2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    mux2_unit_if.slave  bus
);

    logic [WIDTH-1:0] y_comb;

    mux2_sel #(.WIDTH(WIDTH)) u_sel (
        .d0_i (bus.d0),
        .d1_i (bus.d1),
        .s_i  (bus.s),
        .y_o  (y_comb)
    );

    assign bus.y = y_comb;

    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_q, sel_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (bus.en) begin
            data_d  = y_comb;
            sel_d   = bus.s;
            valid_d = 1'b1;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus.y_q     = data_q;
    assign bus.sel_q   = sel_q;
    assign bus.valid_q = valid_q;

`ifdef MUX2_TOGGLE_CNT_EN
    logic             s_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate rather than wrap so a long-running debug count never looks small.
    always_comb begin
        cnt_d = cnt_q;
        if ((bus.s != s_prev_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s_prev_q <= bus.s;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.toggle_cnt = cnt_q;
`else
    assign bus.toggle_cnt = {CNT_W{1'b0}};
`endif

endmodule : mux2_unit

// File: tb/tb_mux2_unit.sv
// Self-checking bench for mux2_unit: directed cases then randomized traffic vs. a behavioural model.
module tb_mux2_unit;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    mux2_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mux2_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [WIDTH-1:0] m_yq;
    logic             m_sel;
    logic             m_valid;
    logic             m_prev;
    int               m_cnt;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sel);
        logic [WIDTH-1:0] choices [2];
        choices[0] = a;
        choices[1] = b;
        return choices[sel];
    endfunction

    task automatic drive(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                         input logic s, input logic en, input logic r);
        bus.d0 = d0;
        bus.d1 = d1;
        bus.s  = s;
        bus.en = en;
        rst    = r;
        #1;
        check("y_comb", 64'(bus.y), 64'(pick(d0, d1, s)));
    endtask

    task automatic tick(input string tag);
        int exp_cnt;
        if (rst) begin
            m_yq = '0; m_sel = 1'b0; m_valid = 1'b0; m_prev = 1'b0; m_cnt = 0;
        end else begin
            if (bus.en) begin
                m_yq    = pick(bus.d0, bus.d1, bus.s);
                m_sel   = bus.s;
                m_valid = 1'b1;
            end
            if (bus.s != m_prev) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_prev = bus.s;
        end
`ifdef MUX2_TOGGLE_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        @(posedge clk);
        #1;
        check({tag, ".y_q"},        64'(bus.y_q),        64'(m_yq));
        check({tag, ".sel_q"},      64'(bus.sel_q),      64'(m_sel));
        check({tag, ".valid_q"},    64'(bus.valid_q),    64'(m_valid));
        check({tag, ".toggle_cnt"}, 64'(bus.toggle_cnt), 64'(exp_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        m_yq = '0; m_sel = 1'b0; m_valid = 1'b0; m_prev = 1'b0; m_cnt = 0;

        // Combinational path before any clock edge matters
        drive(8'h3A, 8'h5F, 1'b0, 1'b0, 1'b1);
        #9;
        check("y_s0", 64'(bus.y), 64'(8'h3A));
        drive(8'h5F == 8'h5F ? 8'h3A : 8'h00, 8'h5F, 1'b1, 1'b0, 1'b1);
        #9;
        check("y_s1", 64'(bus.y), 64'(8'h5F));

        // Reset for two cycles with en asserted
        drive(8'h11, 8'h22, 1'b1, 1'b1, 1'b1);
        tick("rst0");
        drive(8'h33, 8'h44, 1'b0, 1'b1, 1'b1);
        tick("rst1");

        // First capture after reset, then hold with en=0
        drive(8'h3A, 8'h5F, 1'b1, 1'b1, 1'b0);
        tick("cap");
        drive(8'h3A, 8'hAA, 1'b1, 1'b0, 1'b0);
        check("y_hold", 64'(bus.y), 64'(8'hAA));
        tick("hold");

        // Five consecutive toggles drive the counter into saturation
        for (int i = 0; i < 5; i++) begin
            drive(8'h0F, 8'hF0, ~bus.s, 1'b1, 1'b0);
            tick("toggle");
        end
        drive(8'h0F, 8'hF0, ~bus.s, 1'b0, 1'b0);
        tick("sat_hold");

        // Mid-stream reset wins over en
        drive(8'hC3, 8'h3C, 1'b1, 1'b1, 1'b1);
        tick("mid_rst");
        drive(8'hC3, 8'h3C, 1'b1, 1'b1, 1'b0);
        tick("post_rst");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 15) == 0));
            tick("rand");
        end

        // Unknown select with agreeing data inputs
        bus.d0 = 8'h3A;
        bus.d1 = 8'h3A;
        bus.s  = 1'bx;
        #1;
        check("y_sx", 64'(bus.y), 64'(8'h3A));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux2_unit

// File: doc/mux2_unit.md
# mux2_unit

Parameterised 2:1 data selector for the CPU datapath (ALU operand, PC-source and write-back selection). It provides a zero-latency combinational output plus a registered, enable-gated copy for pipelined consumers. An optional counter tracks select toggles for debug and coverage.

## Interface
- WIDTH, 8: data width in bits (≥1).
- CNT_W, 16: toggle-counter width (≥2).
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- d0  input  WIDTH  data input, selected when s=0.
- d1  input  WIDTH  data input, selected when s=1.
- s  input  1  select.
- en  input  1  register-stage capture enable.
- y  output  WIDTH  combinational selected data.
- y_q  output  WIDTH  registered selected data.
- valid_q  output  1  y_q holds data captured since reset.
- sel_q  output  1  select value captured with y_q.
- toggle_cnt  output  CNT_W  count of s changes (only with MUX2_TOGGLE_CNT_EN).

## Operation
- y = d0 when s=0, y = d1 when s=1. This is pure combinational logic, independent of clk, rst and en.
- When s is X/Z, each bit of y equals the d0/d1 value where the two agree and is X elsewhere (standard conditional-operator merge).
- Register stage: on a clock edge with en=1, y_q←y, sel_q←s and valid_q←1. With en=0, all three hold their values.
- Toggle counter: s_prev is registered every cycle. toggle_cnt increments when s≠s_prev and saturates at all-ones (no wrap).
- rst has priority over en and all other inputs.

## Timing
- y: zero cycles. It settles within the same delta/timestep as any change on d0, d1 or s.
- y_q, sel_q, valid_q: 1-cycle latency from the capturing edge.
- Reset values: y_q=0, sel_q=0, valid_q=0, toggle_cnt=0, s_prev=0. y is unaffected by reset.
- Reset asserted mid-stream clears the registered outputs on the next edge even when en=1. The first edge after rst deasserts may capture.
- Simultaneous toggle and saturation: the counter stays at all-ones.
- On the first cycle after reset, s=1 counts as one toggle, because s_prev resets to 0.

## Configuration
- MUX2_TOGGLE_CNT_EN defined: s_prev and the saturating counter are built, and toggle_cnt is driven as specified.
- Undefined: the counter logic is removed, the toggle_cnt port remains, and it is tied to 0.

## Structure
- Package mux2_pkg holds the default WIDTH and CNT_W localparams and the toggle_cnt_t typedef (logic [CNT_W-1:0]).
- One sub-module, mux2_sel: a purely combinational WIDTH-wide selector producing y. The top instantiates it and adds the register stage and the counter.

## Test plan
- WIDTH=8, d0=8'h3A, d1=8'h5F, s=0, wait 10 time units (no clock) → y=8'h3A.
- Then s=1, wait 10 → y=8'h5F.
- rst=1 for 2 cycles with en=1 → y_q=0, sel_q=0, valid_q=0, toggle_cnt=0. y still tracks the inputs.
- en=1, s=1, d1=8'h5F, one edge → y_q=8'h5F, sel_q=1, valid_q=1. Then en=0 and d1=8'hAA → y=8'hAA while y_q stays 8'h5F.
- Macro on, CNT_W=2, s toggled on 5 consecutive cycles → toggle_cnt reaches 3 and holds at 3.
- Macro off, s toggling → toggle_cnt stays 0. s=X with d0=d1=8'h3A → y=8'h3A.
